// File: rtl/accel_pkg.sv
// accel_pkg: shared types and constants for the accelerator sequencer.
// Holds the FSM state encoding, engine ids and the timeout result word.
package accel_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        WB     = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ENG_FFT = 2'd0,
        ENG_ENC = 2'd1,
        ENG_DEC = 2'd2
    } eng_e;

    localparam logic [18:0] ERR_DATA = 19'h7FFFF;

endpackage

// File: rtl/accel_watchdog.sv
// accel_watchdog: WAIT-state cycle counter, used only with ACCEL_TIMEOUT_EN.
// Ports: clk, rst (sync, active-high), clr, en in; expired out.
import accel_pkg::*;

module accel_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Fires during the last allowed cycle, i.e. as the count reaches the limit.
    assign expired = en && !clr && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/accel_sequencer.sv
// accel_sequencer: launches FFT/ENC/DEC engines, stalls the CPU, writes back the result.
// Ports: clk, rst, do_fft/do_encrypt/do_decrypt, op_a/op_b in; eng_start, eng_arg_a/b out;
// eng_done, res_fft/enc/dec in; stall, wb_en, wb_data, busy, err out.
// Optional feature: define ACCEL_TIMEOUT_EN for the WAIT-state timeout and sticky err.
import accel_pkg::*;

module accel_sequencer #(
    parameter int DATA_W         = 19,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              do_fft,
    input  logic              do_encrypt,
    input  logic              do_decrypt,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [2:0]        eng_start,
    output logic [DATA_W-1:0] eng_arg_a,
    output logic [DATA_W-1:0] eng_arg_b,
    input  logic [2:0]        eng_done,
    input  logic [DATA_W-1:0] res_fft,
    input  logic [DATA_W-1:0] res_enc,
    input  logic [DATA_W-1:0] res_dec,
    output logic              stall,
    output logic              wb_en,
    output logic [DATA_W-1:0] wb_data,
    output logic              busy,
    output logic              err
);

    state_e            state_q, state_d;
    eng_e              eng_q, eng_d;
    eng_e              sel_eng;
    logic [DATA_W-1:0] arg_a_q, arg_a_d;
    logic [DATA_W-1:0] arg_b_q, arg_b_d;
    logic [2:0]        start_q, start_d;
    logic              wb_en_q, wb_en_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              any_do;
    logic              done_hit;
    logic [DATA_W-1:0] res_sel;
    logic              timeout;

    assign any_do = do_fft | do_encrypt | do_decrypt;

    always_comb begin
        sel_eng = ENG_DEC;
        priority case (1'b1)
            do_fft:     sel_eng = ENG_FFT;
            do_encrypt: sel_eng = ENG_ENC;
            default:    sel_eng = ENG_DEC;
        endcase
    end

    // Only the launched engine's done bit and result are looked at.
    always_comb begin
        done_hit = eng_done[2];
        res_sel  = res_dec;
        case (eng_q)
            ENG_FFT: begin
                done_hit = eng_done[0];
                res_sel  = res_fft;
            end
            ENG_ENC: begin
                done_hit = eng_done[1];
                res_sel  = res_enc;
            end
            default: begin
                done_hit = eng_done[2];
                res_sel  = res_dec;
            end
        endcase
    end

`ifdef ACCEL_TIMEOUT_EN
    logic err_q;

    accel_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_q == LAUNCH),
        .en      (state_q == WAIT),
        .expired (timeout)
    );

    // A done in the timeout cycle wins, so only flag when no done arrived.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state_q == WAIT && !done_hit && timeout) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        eng_d     = eng_q;
        arg_a_d   = arg_a_q;
        arg_b_d   = arg_b_q;
        start_d   = 3'b000;
        wb_en_d   = 1'b0;
        wb_data_d = wb_data_q;
        stall     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_do) begin
                    stall   = 1'b1;
                    eng_d   = sel_eng;
                    arg_a_d = op_a;
                    arg_b_d = op_b;
                    start_d = 3'b001 << sel_eng;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                stall   = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                stall = 1'b1;
                if (done_hit) begin
                    wb_en_d   = 1'b1;
                    wb_data_d = res_sel;
                    state_d   = WB;
                end else if (timeout) begin
                    wb_en_d   = 1'b1;
                    wb_data_d = DATA_W'(ERR_DATA);
                    state_d   = WB;
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            eng_q     <= ENG_FFT;
            arg_a_q   <= '0;
            arg_b_q   <= '0;
            start_q   <= 3'b000;
            wb_en_q   <= 1'b0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            eng_q     <= eng_d;
            arg_a_q   <= arg_a_d;
            arg_b_q   <= arg_b_d;
            start_q   <= start_d;
            wb_en_q   <= wb_en_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign eng_start = start_q;
    assign eng_arg_a = arg_a_q;
    assign eng_arg_b = arg_b_q;
    assign wb_en     = wb_en_q;
    assign wb_data   = wb_data_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_accel_sequencer.sv
// tb_accel_sequencer: table-driven and randomized checks of accel_sequencer.
// Transactions are checked cycle by cycle against a transaction-level model.
module tb_accel_sequencer;

    localparam int W  = 19;
    localparam int TO = 8;

    logic         clk;
    logic         rst;
    logic         do_fft, do_encrypt, do_decrypt;
    logic [W-1:0] op_a, op_b;
    logic [2:0]   eng_start;
    logic [W-1:0] eng_arg_a, eng_arg_b;
    logic [2:0]   eng_done;
    logic [W-1:0] res_fft, res_enc, res_dec;
    logic         stall, wb_en, busy, err;
    logic [W-1:0] wb_data;

    accel_sequencer #(
        .DATA_W(W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .do_fft     (do_fft),
        .do_encrypt (do_encrypt),
        .do_decrypt (do_decrypt),
        .op_a       (op_a),
        .op_b       (op_b),
        .eng_start  (eng_start),
        .eng_arg_a  (eng_arg_a),
        .eng_arg_b  (eng_arg_b),
        .eng_done   (eng_done),
        .res_fft    (res_fft),
        .res_enc    (res_enc),
        .res_dec    (res_dec),
        .stall      (stall),
        .wb_en      (wb_en),
        .wb_data    (wb_data),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   dos;       // {dec, enc, fft}
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           nwait;     // WAIT cycle of the done pulse, 0 = never
        logic [2:0]   stray;     // foreign done bits to inject
        logic [W-1:0] rf;
        logic [W-1:0] re;
        logic [W-1:0] rd;
        logic [2:0]   exp_start;
        logic [W-1:0] exp_data;
        int           exp_lat;   // WAIT cycles before WB
        bit           exp_to;
    } vec_t;

    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    int           launch_cyc = 0;
    int           wb_cyc = 0;
    bit           err_m = 1'b0;
    logic [W-1:0] last_data = '0;
    vec_t         tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Transaction-level reference: priority pick, result selection, timeout.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        if (v.dos[0]) begin
            r.exp_start = 3'b001;
            r.exp_data  = v.rf;
        end else if (v.dos[1]) begin
            r.exp_start = 3'b010;
            r.exp_data  = v.re;
        end else begin
            r.exp_start = 3'b100;
            r.exp_data  = v.rd;
        end
        r.exp_lat = v.nwait;
        r.exp_to  = 1'b0;
`ifdef ACCEL_TIMEOUT_EN
        if (v.nwait == 0 || v.nwait > TO) begin
            r.exp_lat  = TO;
            r.exp_data = 19'h7FFFF;
            r.exp_to   = 1'b1;
        end
`endif
        return r;
    endfunction

    task automatic idle();
        do_fft     = 1'b0;
        do_encrypt = 1'b0;
        do_decrypt = 1'b0;
        eng_done   = 3'b000;
        #1;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_stall", 32'(stall), 32'd0);
        chk("idle_wb_en", 32'(wb_en), 32'd0);
        chk("idle_wb_hold", 32'(wb_data), 32'(last_data));
        chk("idle_start", 32'(eng_start), 32'd0);
        tick();
    endtask

    // Starts in an IDLE cycle; returns at the start of the cycle after WB.
    // The strobe stays high while stalled and through WB, as real decode would.
    task automatic run_op(input vec_t v);
        do_fft     = v.dos[0];
        do_encrypt = v.dos[1];
        do_decrypt = v.dos[2];
        op_a       = v.a;
        op_b       = v.b;
        eng_done   = 3'b000;
        #1;
        chk("strobe_stall", 32'(stall), 32'd1);
        chk("strobe_busy", 32'(busy), 32'd0);
        tick();
        launch_cyc = cyc;
        op_a       = W'($urandom);
        op_b       = W'($urandom);
        eng_done   = (v.stray != 3'b000) ? 3'b111 : 3'b000;
        #1;
        chk("launch_start", 32'(eng_start), 32'(v.exp_start));
        chk("launch_arg_a", 32'(eng_arg_a), 32'(v.a));
        chk("launch_arg_b", 32'(eng_arg_b), 32'(v.b));
        chk("launch_stall", 32'(stall), 32'd1);
        chk("launch_busy", 32'(busy), 32'd1);
        for (int k = 1; k <= v.exp_lat; k++) begin
            tick();
            eng_done = v.stray & ~v.exp_start;
            res_fft  = W'($urandom);
            res_enc  = W'($urandom);
            res_dec  = W'($urandom);
            if (k == v.nwait) begin
                eng_done = eng_done | v.exp_start;
                res_fft  = v.rf;
                res_enc  = v.re;
                res_dec  = v.rd;
            end
            #1;
            chk("wait_stall", 32'(stall), 32'd1);
            chk("wait_start", 32'(eng_start), 32'd0);
            chk("wait_wb_en", 32'(wb_en), 32'd0);
            chk("wait_arg_a", 32'(eng_arg_a), 32'(v.a));
            chk("wait_arg_b", 32'(eng_arg_b), 32'(v.b));
        end
        tick();
        wb_cyc   = cyc;
        eng_done = 3'b000;
        res_fft  = W'($urandom);
        res_enc  = W'($urandom);
        res_dec  = W'($urandom);
        if (v.exp_to) err_m = 1'b1;
        last_data = v.exp_data;
        #1;
        chk("wb_en", 32'(wb_en), 32'd1);
        chk("wb_data", 32'(wb_data), 32'(v.exp_data));
        chk("wb_stall", 32'(stall), 32'd0);
        chk("wb_busy", 32'(busy), 32'd1);
        chk("wb_err", 32'(err), 32'(err_m));
        chk("wb_arg_a", 32'(eng_arg_a), 32'(v.a));
        tick();
    endtask

    initial begin
        vec_t v, v2;
        int   w1;

        rst        = 1'b1;
        do_fft     = 1'b0;
        do_encrypt = 1'b0;
        do_decrypt = 1'b0;
        op_a       = '0;
        op_b       = '0;
        eng_done   = 3'b000;
        res_fft    = '0;
        res_enc    = '0;
        res_dec    = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_start", 32'(eng_start), 32'd0);
        chk("rst_arg_a", 32'(eng_arg_a), 32'd0);
        chk("rst_arg_b", 32'(eng_arg_b), 32'd0);
        chk("rst_wb_en", 32'(wb_en), 32'd0);
        chk("rst_wb_data", 32'(wb_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        tick();

        // dos, a, b, nwait, stray, rf, re, rd, exp_start, exp_data, exp_lat, exp_to
        tbl.push_back('{3'b010, 19'h00012, 19'h00034, 1, 3'b000,
                        19'h11111, 19'h12345, 19'h54321, 3'b010, 19'h12345, 1, 1'b0});
        tbl.push_back('{3'b101, 19'h00abc, 19'h00def, 2, 3'b100,
                        19'h0abcd, 19'h22222, 19'h7fffe, 3'b001, 19'h0abcd, 2, 1'b0});
`ifdef ACCEL_TIMEOUT_EN
        tbl.push_back('{3'b100, 19'h3c3c3, 19'h43434, 50, 3'b011,
                        19'h01010, 19'h02020, 19'h13579, 3'b100, 19'h7ffff, 8, 1'b1});
        tbl.push_back('{3'b001, 19'h00001, 19'h00002, 8, 3'b110,
                        19'h0f0f0, 19'h0e0e0, 19'h0d0d0, 3'b001, 19'h0f0f0, 8, 1'b0});
        tbl.push_back('{3'b010, 19'h00005, 19'h00006, 0, 3'b000,
                        19'h0aaaa, 19'h0bbbb, 19'h0cccc, 3'b010, 19'h7ffff, 8, 1'b1});
`else
        tbl.push_back('{3'b100, 19'h3c3c3, 19'h43434, 50, 3'b011,
                        19'h01010, 19'h02020, 19'h13579, 3'b100, 19'h13579, 50, 1'b0});
`endif
        tbl.push_back('{3'b111, 19'h55555, 19'h2aaaa, 3, 3'b110,
                        19'h00777, 19'h00888, 19'h00999, 3'b001, 19'h00777, 3, 1'b0});
        tbl.push_back('{3'b110, 19'h7ffff, 19'h00000, 2, 3'b101,
                        19'h01234, 19'h04321, 19'h05678, 3'b010, 19'h04321, 2, 1'b0});
        tbl.push_back('{3'b001, 19'h7ffff, 19'h00000, 4, 3'b111,
                        19'h00000, 19'h7ffff, 19'h7ffff, 3'b001, 19'h00000, 4, 1'b0});

        foreach (tbl[i]) begin
            run_op(tbl[i]);
            idle();
        end

        // Back-to-back: the second strobe is seen in the IDLE cycle after WB.
        v = '{3'b001, 19'h00101, 19'h00202, 1, 3'b000,
              19'h01111, 19'h02222, 19'h03333, 3'b000, '0, 0, 1'b0};
        v2 = '{3'b100, 19'h00303, 19'h00404, 2, 3'b000,
               19'h04444, 19'h05555, 19'h06666, 3'b000, '0, 0, 1'b0};
        run_op(model(v));
        w1 = wb_cyc;
        run_op(model(v2));
        chk("b2b_gap", 32'(launch_cyc - w1), 32'd2);
        idle();

        for (int n = 0; n < 25; n++) begin
            v.dos = 3'($urandom_range(1, 7));
            v.a   = W'($urandom);
            v.b   = W'($urandom);
`ifdef ACCEL_TIMEOUT_EN
            v.nwait = $urandom_range(0, 10);
`else
            v.nwait = $urandom_range(1, 6);
`endif
            v.stray = 3'($urandom);
            v.rf    = W'($urandom);
            v.re    = W'($urandom);
            v.rd    = W'($urandom);
            run_op(model(v));
            for (int g = $urandom_range(0, 2); g > 0; g--) idle();
        end
        idle();

        // Reset during WAIT: abort, no write-back, later done ignored.
        do_decrypt = 1'b1;
        op_a       = 19'h01111;
        op_b       = 19'h02222;
        tick();
        tick();
        tick();
        #1;
        chk("rwait_stall", 32'(stall), 32'd1);
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        do_decrypt = 1'b0;
        err_m      = 1'b0;
        last_data  = '0;
        #1;
        chk("rwait_busy", 32'(busy), 32'd0);
        chk("rwait_stall0", 32'(stall), 32'd0);
        chk("rwait_wb_en", 32'(wb_en), 32'd0);
        chk("rwait_start", 32'(eng_start), 32'd0);
        chk("rwait_arg_a", 32'(eng_arg_a), 32'd0);
        chk("rwait_wb_data", 32'(wb_data), 32'd0);
        chk("rwait_err", 32'(err), 32'd0);
        eng_done = 3'b100;
        res_dec  = 19'h33333;
        tick();
        eng_done = 3'b000;
        #1;
        chk("late_done_wb", 32'(wb_en), 32'd0);
        chk("late_done_busy", 32'(busy), 32'd0);
        tick();
        #1;
        chk("late_done_wb2", 32'(wb_en), 32'd0);
        chk("late_done_data", 32'(wb_data), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
